// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - opcode classes, instruction field helpers and history entry type
package fwd_hazard_unit_pkg;

    localparam int FWD_DATA_W  = 8;
    localparam int FWD_REG_AW  = 3;
    localparam int FWD_INSTR_W = 2 + 2 * FWD_REG_AW;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_IMM   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_JMP   = 2'b11;

    // The history entry is sized by the package widths, so the core widths are set here.
    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] addr;
        logic                  is_load;
        logic [FWD_DATA_W-1:0] data;
    } hist_entry_t;

    function automatic logic [1:0] instr_op(input logic [FWD_INSTR_W-1:0] instr);
        return instr[FWD_INSTR_W-1 -: 2];
    endfunction

    function automatic logic [FWD_REG_AW-1:0] instr_dst(input logic [FWD_INSTR_W-1:0] instr);
        return instr[2*FWD_REG_AW-1 -: FWD_REG_AW];
    endfunction

    function automatic logic [FWD_REG_AW-1:0] instr_src(input logic [FWD_INSTR_W-1:0] instr);
        return instr[FWD_REG_AW-1:0];
    endfunction

    function automatic logic uses_op0(input logic [1:0] op);
        return op == OP_RTYPE;
    endfunction

    function automatic logic uses_op1(input logic [1:0] op);
        return op != OP_JMP;
    endfunction

    function automatic logic is_writer(input logic [1:0] op);
        return op != OP_JMP;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - issue-side bundle between regfile read and execute operand latches
interface fwd_hazard_unit_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 3
);
    localparam int INSTR_W = 2 + 2 * REG_AW;
    localparam int SEL_W   = $clog2(DEPTH + 1);

    logic               issue_valid;
    logic [INSTR_W-1:0] issue_instr;
    logic [DATA_W-1:0]  reg_src_dat;
    logic [DATA_W-1:0]  reg_dst_dat;
    logic [DATA_W-1:0]  ex_res;
    logic [DATA_W-1:0]  mem_res;
    logic               flush;
    logic [DATA_W-1:0]  in0;
    logic [DATA_W-1:0]  in1;
    logic [SEL_W-1:0]   sel0;
    logic [SEL_W-1:0]   sel1;
    logic               stall;

    modport master (
        output issue_valid, issue_instr, reg_src_dat, reg_dst_dat, ex_res, mem_res, flush,
        input  in0, in1, sel0, sel1, stall
    );

    modport slave (
        input  issue_valid, issue_instr, reg_src_dat, reg_dst_dat, ex_res, mem_res, flush,
        output in0, in1, sel0, sel1, stall
    );

endinterface

// File: rtl/fwd_match_sel.sv
// rtl/fwd_match_sel.sv - youngest-producer priority match over the history for one operand
module fwd_match_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W  = FWD_DATA_W,
    parameter int REG_AW  = FWD_REG_AW,
    parameter int DEPTH   = 3,
    parameter int R0_ZERO = 0,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_used,
    input  logic [REG_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_reg_dat,
    input  logic [DEPTH-1:0]  i_valid,
    input  logic [REG_AW-1:0] i_hist_addr [DEPTH],
    input  logic [DATA_W-1:0] i_eff_dat   [DEPTH],
    input  logic              i_load0,
    output logic [DATA_W-1:0] o_dat,
    output logic [SEL_W-1:0]  o_sel,
    output logic              o_load_use
);

    logic w_en;

    assign w_en = i_used && !((R0_ZERO != 0) && (i_addr == '0));

    // Scan oldest to youngest so the lowest matching index is the last one written.
    always_comb begin
        o_dat      = i_reg_dat;
        o_sel      = '0;
        o_load_use = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_en && i_valid[k] && (i_hist_addr[k] == i_addr)) begin
                o_dat      = i_eff_dat[k];
                o_sel      = SEL_W'(k + 1);
                o_load_use = (k == 0) && i_load0;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - multi-entry operand forwarding with load-use stall and flush
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W  = FWD_DATA_W,
    parameter int REG_AW  = FWD_REG_AW,
    parameter int DEPTH   = 3,
    parameter int R0_ZERO = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    fwd_hazard_unit_if.slave bus
);

    localparam int SEL_W = $clog2(DEPTH + 1);

    hist_entry_t       r_hist      [DEPTH];
    logic [DATA_W-1:0] w_eff_dat   [DEPTH];
    logic [REG_AW-1:0] w_hist_addr [DEPTH];
    logic [DEPTH-1:0]  w_valid;

    logic [1:0]        w_op;
    logic [REG_AW-1:0] w_dst;
    logic [REG_AW-1:0] w_src;
    logic              w_lu0;
    logic              w_lu1;
    logic              w_stall;
    logic              w_accept;
    logic [DATA_W-1:0] w_in0;
    logic [DATA_W-1:0] w_in1;
    logic [SEL_W-1:0]  w_sel0;
    logic [SEL_W-1:0]  w_sel1;

    assign w_op  = instr_op(bus.issue_instr);
    assign w_dst = instr_dst(bus.issue_instr);
    assign w_src = instr_src(bus.issue_instr);

    // A load sitting in entry 0 has no data yet; its value shows up on mem_res one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i]     = r_hist[i].valid;
            w_hist_addr[i] = r_hist[i].addr;
            w_eff_dat[i]   = r_hist[i].data;
            if (i == 0) begin
                w_eff_dat[i] = r_hist[i].is_load ? '0 : bus.ex_res;
            end else if ((i == 1) && r_hist[i].is_load) begin
                w_eff_dat[i] = bus.mem_res;
            end
        end
    end

    fwd_match_sel #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO)
    ) u_match0 (
        .i_used      (uses_op0(w_op)),
        .i_addr      (w_src),
        .i_reg_dat   (bus.reg_src_dat),
        .i_valid     (w_valid),
        .i_hist_addr (w_hist_addr),
        .i_eff_dat   (w_eff_dat),
        .i_load0     (r_hist[0].is_load),
        .o_dat       (w_in0),
        .o_sel       (w_sel0),
        .o_load_use  (w_lu0)
    );

    fwd_match_sel #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO)
    ) u_match1 (
        .i_used      (uses_op1(w_op)),
        .i_addr      (w_dst),
        .i_reg_dat   (bus.reg_dst_dat),
        .i_valid     (w_valid),
        .i_hist_addr (w_hist_addr),
        .i_eff_dat   (w_eff_dat),
        .i_load0     (r_hist[0].is_load),
        .o_dat       (w_in1),
        .o_sel       (w_sel1),
        .o_load_use  (w_lu1)
    );

    assign w_stall  = bus.issue_valid && !bus.flush && (w_lu0 || w_lu1);
    assign w_accept = bus.issue_valid && !bus.flush && !w_stall;

    assign bus.in0   = w_in0;
    assign bus.in1   = w_in1;
    assign bus.sel0  = w_sel0;
    assign bus.sel1  = w_sel1;
    assign bus.stall = w_stall;

    // Every edge shifts the history; a flush kills entry 0 as it moves into entry 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_hist[0].valid   <= w_accept && is_writer(w_op) && !((R0_ZERO != 0) && (w_dst == '0));
            r_hist[0].addr    <= w_dst;
            r_hist[0].is_load <= (w_op == OP_LOAD);
            r_hist[0].data    <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_hist[i].valid   <= r_hist[i-1].valid && !((i == 1) && bus.flush);
                r_hist[i].addr    <= r_hist[i-1].addr;
                r_hist[i].is_load <= r_hist[i-1].is_load;
                r_hist[i].data    <= w_eff_dat[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench with a cycle-log reference model
module tb_fwd_hazard_unit;

    localparam int DEPTH = 3;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    int   now;

    typedef struct {
        int cyc;
        int dst;
        bit ld;
    } rec_t;

    rec_t      wq0[$];
    rec_t      wq1[$];
    logic [7:0] ex_at    [4096];
    logic [7:0] mem_at   [4096];
    bit         flush_at [4096];

    fwd_hazard_unit_if #(.DATA_W(8), .REG_AW(3), .DEPTH(DEPTH)) if0 ();
    fwd_hazard_unit_if #(.DATA_W(8), .REG_AW(3), .DEPTH(DEPTH)) if1 ();

    fwd_hazard_unit #(.DATA_W(8), .REG_AW(3), .DEPTH(DEPTH), .R0_ZERO(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    fwd_hazard_unit #(.DATA_W(8), .REG_AW(3), .DEPTH(DEPTH), .R0_ZERO(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] instr, input logic [7:0] rs,
                         input logic [7:0] rd, input logic [7:0] ex, input logic [7:0] mem,
                         input logic fl);
        if0.issue_valid = v;  if1.issue_valid = v;
        if0.issue_instr = instr; if1.issue_instr = instr;
        if0.reg_src_dat = rs; if1.reg_src_dat = rs;
        if0.reg_dst_dat = rd; if1.reg_dst_dat = rd;
        if0.ex_res = ex;      if1.ex_res = ex;
        if0.mem_res = mem;    if1.mem_res = mem;
        if0.flush = fl;       if1.flush = fl;
        #1;
    endtask

    // Youngest accepted, unkilled writer of addr issued within the last DEPTH cycles.
    function automatic void find(input int v, input int addr, output int age, output bit ld,
                                 output int cyc);
        rec_t q[$];
        q = (v == 1) ? wq1 : wq0;
        age = -1; ld = 0; cyc = -1;
        foreach (q[j]) begin
            int c;
            c = q[j].cyc;
            if (c >= now - DEPTH && c <= now - 1 && q[j].dst == addr && !(v == 1 && addr == 0)
                && !(c + 1 < now && flush_at[c+1]) && c > cyc) begin
                cyc = c;
                ld  = q[j].ld;
                age = now - 1 - c;
            end
        end
    endfunction

    function automatic void model_eval(input int v, output bit st, output int o0, output int o1,
                                       output int s0, output int s1);
        int op, dst, src, a0, a1, c0, c1;
        bit u0, u1, ld0, ld1;
        ex_at[now] = if0.ex_res;
        mem_at[now] = if0.mem_res;
        flush_at[now] = if0.flush;
        op = int'(if0.issue_instr[7:6]);
        dst = int'(if0.issue_instr[5:3]);
        src = int'(if0.issue_instr[2:0]);
        u0 = (op == 0);
        u1 = (op != 3);
        find(v, src, a0, ld0, c0);
        find(v, dst, a1, ld1, c1);
        o0 = int'(if0.reg_src_dat); s0 = 0;
        o1 = int'(if0.reg_dst_dat); s1 = 0;
        if (u0 && a0 >= 0) begin
            s0 = a0 + 1;
            o0 = ld0 ? int'(mem_at[c0+2]) : int'(ex_at[c0+1]);
        end
        if (u1 && a1 >= 0) begin
            s1 = a1 + 1;
            o1 = ld1 ? int'(mem_at[c1+2]) : int'(ex_at[c1+1]);
        end
        st = if0.issue_valid && !if0.flush && ((u0 && a0 == 0 && ld0) || (u1 && a1 == 0 && ld1));
    endfunction

    task automatic tick();
        bit st;
        int e0, e1, es0, es1, op, dst;
        rec_t r;
        op = int'(if0.issue_instr[7:6]);
        dst = int'(if0.issue_instr[5:3]);
        for (int v = 0; v < 2; v++) begin
            model_eval(v, st, e0, e1, es0, es1);
            if (rst_n && if0.issue_valid && !if0.flush && !st && op != 3 && !(v == 1 && dst == 0)) begin
                r.cyc = now; r.dst = dst; r.ld = (op == 2);
                if (v == 0) wq0.push_back(r); else wq1.push_back(r);
            end
        end
        now++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        wq0.delete();
        wq1.delete();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wq0.delete();
        wq1.delete();
        drive(1'b1, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        total_cnt++;
        if ({if0.in0, if0.in1} !== 16'h1122) $display("FAIL reset_in got %h exp 1122", {if0.in0, if0.in1});
        else pass_cnt++;
        total_cnt++;
        if ({if0.sel0, if0.sel1, if0.stall} !== 5'b0) $display("FAIL reset_sel_stall got %b exp 00000", {if0.sel0, if0.sel1, if0.stall});
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        total_cnt++;
        if ({if0.in0, if0.in1, if0.sel0, if0.sel1, if0.stall} !== {16'h1122, 5'b0})
            $display("FAIL reset_release got %h exp %h", {if0.in0, if0.in1, if0.sel0, if0.sel1, if0.stall}, {16'h1122, 5'b0});
        else pass_cnt++;
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        drive(1'b1, 8'h4B, 8'h01, 8'h02, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h08, 8'hA1, 8'hA2, 8'h5A, 8'h00, 1'b0);
        total_cnt++;
        if (if0.in1 !== 8'h5A || if0.sel1 !== 2'd1) $display("FAIL alu_b2b_in1 got %h/%0d exp 5a/1", if0.in1, if0.sel1);
        else pass_cnt++;
        total_cnt++;
        if (if0.in0 !== 8'hA1 || if0.sel0 !== 2'd0) $display("FAIL alu_b2b_in0 got %h/%0d exp a1/0", if0.in0, if0.sel0);
        else pass_cnt++;
    endtask

    task automatic test_youngest_wins();
        do_reset();
        drive(1'b1, 8'h48, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h48, 8'h00, 8'h00, 8'h10, 8'h00, 1'b0);
        tick();
        drive(1'b0, 8'h08, 8'h00, 8'hB0, 8'h20, 8'h00, 1'b0);
        total_cnt++;
        if (if0.in1 !== 8'h20 || if0.sel1 !== 2'd1) $display("FAIL youngest_e0 got %h/%0d exp 20/1", if0.in1, if0.sel1);
        else pass_cnt++;
        tick();
        drive(1'b0, 8'h08, 8'h00, 8'hB0, 8'hEE, 8'hDD, 1'b0);
        total_cnt++;
        if (if0.in1 !== 8'h20 || if0.sel1 !== 2'd2) $display("FAIL youngest_e1 got %h/%0d exp 20/2", if0.in1, if0.sel1);
        else pass_cnt++;
        tick();
        drive(1'b0, 8'h08, 8'h00, 8'hB0, 8'hEE, 8'hDD, 1'b0);
        total_cnt++;
        if (if0.in1 !== 8'h20 || if0.sel1 !== 2'd3) $display("FAIL youngest_e2 got %h/%0d exp 20/3", if0.in1, if0.sel1);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 8'h8B, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h08, 8'hC1, 8'hC2, 8'h99, 8'h00, 1'b0);
        total_cnt++;
        if (if0.stall !== 1'b1) $display("FAIL load_use_stall got %b exp 1", if0.stall);
        else pass_cnt++;
        tick();
        drive(1'b1, 8'h08, 8'hC1, 8'hC2, 8'h99, 8'h77, 1'b0);
        total_cnt++;
        if ({if0.stall, if0.in1, if0.sel1} !== {1'b0, 8'h77, 2'd2})
            $display("FAIL load_use_fwd got %h exp %h", {if0.stall, if0.in1, if0.sel1}, {1'b0, 8'h77, 2'd2});
        else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h08, 8'h00, 8'h00, 8'h31, 8'h00, 1'b1);
        tick();
        drive(1'b1, 8'h08, 8'hD1, 8'hD2, 8'h32, 8'h00, 1'b0);
        total_cnt++;
        if ({if0.in1, if0.sel1, if0.stall} !== {8'hD2, 2'd0, 1'b0})
            $display("FAIL flush_kill got %h exp %h", {if0.in1, if0.sel1, if0.stall}, {8'hD2, 2'd0, 1'b0});
        else pass_cnt++;
        do_reset();
        drive(1'b1, 8'h8B, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        total_cnt++;
        if (if0.stall !== 1'b0) $display("FAIL flush_over_stall got %b exp 0", if0.stall);
        else pass_cnt++;
    endtask

    task automatic test_branch_r0();
        do_reset();
        drive(1'b1, 8'hCB, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h08, 8'hE1, 8'hE2, 8'h44, 8'h55, 1'b0);
        total_cnt++;
        if ({if0.in1, if0.sel1} !== {8'hE2, 2'd0}) $display("FAIL branch_no_fwd got %h exp e20", {if0.in1, if0.sel1});
        else pass_cnt++;
        do_reset();
        drive(1'b1, 8'h83, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h00, 8'hF1, 8'hF2, 8'h44, 8'h55, 1'b0);
        total_cnt++;
        if (if0.stall !== 1'b1) $display("FAIL r0_plain_stall got %b exp 1", if0.stall);
        else pass_cnt++;
        total_cnt++;
        if ({if1.stall, if1.in0, if1.in1, if1.sel0, if1.sel1} !== {1'b0, 8'hF1, 8'hF2, 4'd0})
            $display("FAIL r0_zero got %h exp %h", {if1.stall, if1.in0, if1.in1, if1.sel0, if1.sel1}, {1'b0, 8'hF1, 8'hF2, 4'd0});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 8'h8B, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h09, 8'h61, 8'h62, 8'h00, 8'h00, 1'b0);
        total_cnt++;
        if (if0.stall !== 1'b1) $display("FAIL mid_stall_pre got %b exp 1", if0.stall);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({if0.stall, if0.in0, if0.in1, if0.sel0, if0.sel1} !== {1'b0, 8'h61, 8'h62, 4'd0})
            $display("FAIL mid_stall_reset got %h exp %h", {if0.stall, if0.in0, if0.in1, if0.sel0, if0.sel1}, {1'b0, 8'h61, 8'h62, 4'd0});
        else pass_cnt++;
        wq0.delete();
        wq1.delete();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        bit st;
        int e0, e1, es0, es1;
        logic [20:0] got, exp;
        logic [7:0] instr;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            instr = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
            drive(($urandom % 10) < 8, instr, 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), ($urandom % 10) == 0);
            for (int v = 0; v < 2; v++) begin
                model_eval(v, st, e0, e1, es0, es1);
                got = (v == 0) ? {if0.stall, if0.in0, if0.in1, if0.sel0, if0.sel1}
                               : {if1.stall, if1.in0, if1.in1, if1.sel0, if1.sel1};
                exp = {st, 8'(e0), 8'(e1), 2'(es0), 2'(es1)};
                total_cnt++;
                if (st ? (got[20] !== 1'b1) : (got !== exp))
                    $display("FAIL rand_dut%0d cyc %0d got %h exp %h", v, now, got, exp);
                else pass_cnt++;
            end
            tick();
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        now = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        test_reset();
        test_alu_back_to_back();
        test_youngest_wins();
        test_load_use();
        test_flush();
        test_branch_r0();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand forwarding and hazard unit for the pipelined core. It is the successor of the single-entry combinational forwarder.
- Keeps a DEPTH-entry history of in-flight register writers and selects the youngest matching producer per operand.
- Stalls issue on a load-use hazard and supports a flush from branch resolution.
- Sits between register-file read and the execute-stage operand latches.

Parameters:
- DATA_W, 8, operand and result width.
- REG_AW, 3, register address width; INSTR_W = 2 + 2*REG_AW.
- DEPTH, 3, number of history entries (min 2); entries older than DEPTH are architecturally in the register file.
- R0_ZERO, 0, when 1, register 0 is never forwarded and never causes a stall.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction present at issue
- issue_instr  in  INSTR_W  [top:top-1] opcode, [2*REG_AW-1:REG_AW] dst/rt field, [REG_AW-1:0] src field
- reg_src_dat  in  DATA_W  register-file read of the src field
- reg_dst_dat  in  DATA_W  register-file read of the dst field
- ex_res  in  DATA_W  execute result of the entry-0 instruction (ALU ops)
- mem_res  in  DATA_W  load data of the entry-1 instruction
- flush  in  1  kill current issue and the entry-0 instruction
- in0  out  DATA_W  forwarded operand 0
- in1  out  DATA_W  forwarded operand 1
- sel0  out  $clog2(DEPTH+1)  source of in0: 0 = regfile, k = entry k-1
- sel1  out  $clog2(DEPTH+1)  source of in1, same encoding
- stall  out  1  hold issue this cycle

Behaviour:
- Opcode classes:
  - 00: R-type; reads src and dst, writes dst.
  - 01: ALU-immediate; reads dst, writes dst.
  - 10: load; reads dst, writes dst, result arrives one cycle later than ALU.
  - 11: branch/jump; reads nothing, writes nothing.
- Operand 0 is used only for opcode 00. Operand 1 is used for any opcode except 11.
- History entry fields: valid, addr, is_load, data. Entry 0 is the instruction accepted in the previous cycle.
- Effective data per entry:
  - Entry 0: ex_res if not a load; a load in entry 0 has no data yet.
  - Entry 1: mem_res if a load, else stored data.
  - Entries 2 and above: stored data.
- Forwarding (combinational):
  - For each used operand, scan entries 0..DEPTH-1 and pick the lowest-index valid entry with addr equal to the operand field.
  - If found, output its effective data and sel = index+1; otherwise output the regfile data and sel = 0.
  - Unused operands always pass regfile data with sel = 0.
- Stall:
  - stall = issue_valid & !flush & (some used operand's youngest match is an entry-0 load).
  - While stalled, in0/in1 are don't-care and the issue is not accepted.
- Clock edge, history always advances:
  - entry[i+1] <= entry[i], and data captures the effective data.
  - entry[0] <= accepted issue with valid = writer class, addr = dst field, is_load = (opcode == 10). An accepted issue means issue_valid & !stall & !flush.
  - Otherwise entry[0] is a bubble (valid = 0).
  - The oldest entry drops out; it has been written to the register file the same cycle.
- flush:
  - The current issue is not accepted, regardless of stall.
  - Entry 0 is invalidated as it shifts into entry 1 (its data is discarded).
- R0_ZERO=1: address 0 never matches, and writers to r0 enter the history as valid = 0.
- Reset (async, rst_n low): all entries valid = 0, data = 0.
  - stall = 0, in0 = reg_src_dat, in1 = reg_dst_dat, sel0 = sel1 = 0.
  - Reset asserted mid-stall drops the hazard immediately.
- Simultaneous matches: the youngest entry wins. Operands 0 and 1 may both select the same entry.

Decomposition:
- Shared package holds:
  - opcode localparams OP_RTYPE=2'b00, OP_IMM=2'b01, OP_LOAD=2'b10, OP_JMP=2'b11
  - field-slice helper functions
  - the history-entry struct typedef
- One natural sub-module, fwd_match_sel: a priority match over the history for one operand, instantiated twice.

Test Plan (DATA_W=8, REG_AW=3, DEPTH=3):
- Reset: rst_n=0 then 1, issue 0x0A (00 001 010), reg_src_dat=0x11, reg_dst_dat=0x22 -> in0=0x11, in1=0x22, sel0=sel1=0, stall=0.
- ALU back-to-back: issue 0x4B (01 001 011), next cycle issue 0x08 (00 001 000) with ex_res=0x5A -> in1=0x5A, sel1=1, in0=regfile, sel0=0.
- Youngest wins: write r1 with 0x10, then 0x20, then read r1 -> in1 = the newer value (0x20) with sel1=1; after two bubbles -> sel1=3, data 0x20.
- Load-use: issue load 0x8B (10 001 011), next cycle issue 0x08 -> stall=1 for one cycle; following cycle mem_res=0x77 -> in1=0x77, sel1=2, stall=0.
- Flush: issue 0x4B, next cycle flush=1 with issue 0x08 -> instruction not accepted; the cycle after, a read of r1 gives in1=reg_dst_dat, sel1=0.
- Branch and R0: issue opcode 11 writing field 001 then read r1 -> no forward. With R0_ZERO=1, write r0 then read r0 -> sel=0, stall=0 even for a load.
